// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered 2:1 data mux between two requesters, with bounded grant hold.
// Optional grant statistics counters enabled by defining ARB_STATS_EN.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Din1,
    input  logic             Req2,
    input  logic [WIDTH-1:0] Din2,
    output logic             Gnt1,
    output logic             Gnt2,
    output logic             Sel,
    output logic [WIDTH-1:0] Dout,
    output logic             Dout_valid
`ifdef ARB_STATS_EN
    ,
    input  logic             Clr_stats,
    output logic [CNT_W-1:0] Cnt1,
    output logic [CNT_W-1:0] Cnt2
`endif
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    if (MAX_HOLD < 1 || CNT_W < 1) begin : g_bad_params
        $error("mux_rr_arbiter: MAX_HOLD and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_last2;
    logic              w_last2_nxt;
    logic              r_sel;
    logic              w_sel_nxt;
    logic [WIDTH-1:0]  r_dout;
    logic              r_dout_valid;
    logic              w_acc1;
    logic              w_acc2;

    assign w_acc1 = (r_state == ST_GRANT1) && Req1;
    assign w_acc2 = (r_state == ST_GRANT2) && Req2;

    // r_last2 = 1 means requester 2 held the mux last, so requester 1 wins a tie
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_last2_nxt = r_last2;
        unique case (r_state)
            ST_IDLE: begin
                if (Req1 && Req2)  w_state_nxt = r_last2 ? ST_GRANT1 : ST_GRANT2;
                else if (Req1)     w_state_nxt = ST_GRANT1;
                else if (Req2)     w_state_nxt = ST_GRANT2;
            end
            ST_GRANT1: begin
                if (!Req1) begin
                    w_state_nxt = Req2 ? ST_GRANT2 : ST_IDLE;
                    w_hold_nxt  = '0;
                    w_last2_nxt = 1'b0;
                end else if (r_hold == HOLD_LAST) begin
                    if (Req2) begin
                        w_state_nxt = ST_GRANT2;
                        w_hold_nxt  = '0;
                        w_last2_nxt = 1'b0;
                    end
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            ST_GRANT2: begin
                if (!Req2) begin
                    w_state_nxt = Req1 ? ST_GRANT1 : ST_IDLE;
                    w_hold_nxt  = '0;
                    w_last2_nxt = 1'b1;
                end else if (r_hold == HOLD_LAST) begin
                    if (Req1) begin
                        w_state_nxt = ST_GRANT1;
                        w_hold_nxt  = '0;
                        w_last2_nxt = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = '0;
            end
        endcase

        w_sel_nxt = r_sel;
        if (w_state_nxt == ST_GRANT1)      w_sel_nxt = 1'b1;
        else if (w_state_nxt == ST_GRANT2) w_sel_nxt = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_last2 <= 1'b1;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_last2 <= w_last2_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_acc1) begin
            r_dout       <= Din1;
            r_dout_valid <= 1'b1;
        end else if (w_acc2) begin
            r_dout       <= Din2;
            r_dout_valid <= 1'b1;
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign Gnt1       = (r_state == ST_GRANT1);
    assign Gnt2       = (r_state == ST_GRANT2);
    assign Sel        = r_sel;
    assign Dout       = r_dout;
    assign Dout_valid = r_dout_valid;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt1;
    logic [CNT_W-1:0] r_cnt2;

    // Clear takes priority over a same-cycle increment; counters stick at all-ones
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (Clr_stats) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else begin
            if (w_acc1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
            if (w_acc2 && (r_cnt2 != '1)) r_cnt2 <= r_cnt2 + 1'b1;
        end
    end

    assign Cnt1 = r_cnt1;
    assign Cnt2 = r_cnt2;
`endif

endmodule
